// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: paces the traffic light sequencer.
// Decodes the lamp pattern into a phase and times each phase from its entry.
// Each dwell is counted in prescaler ticks. When the dwell expires, one step pulse
// drives the sequencer. Main green is extended while there is no demand. Illegal
// lamp patterns, or lamps that do not change after a step, latch a sticky fault.
module traffic_phase_timer #(
    parameter int CLK_PER_TICK = 50_000_000,
    parameter int CNT_W        = 8,
    parameter int T_MAIN_GRN   = 20,
    parameter int T_YEL        = 3,
    parameter int T_ALLRED     = 2,
    parameter int T_SIDE_GRN   = 10,
    parameter int T_PED        = 8,
    parameter int T_CHG_TO     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             MG,
    input  logic             MY,
    input  logic             MR,
    input  logic             SG,
    input  logic             SY,
    input  logic             SR,
    input  logic             pedLight,
    input  logic             pedOn,
    input  logic             sideReq,
    output logic             step,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remaining,
    output logic             fault,
    output logic             flash
);

    localparam int PRESC_W = $clog2(CLK_PER_TICK);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1'b1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_TICK - 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    // The change watchdog faults on the tick that brings its count up to T_CHG_TO.
    localparam logic [CNT_W-1:0] CHG_LAST = (T_CHG_TO > 0) ? CNT_W'(T_CHG_TO - 1) : CNT_ZERO;

    // Phase codes seen on the phase output.
    localparam logic [2:0] PH_GR  = 3'd0;
    localparam logic [2:0] PH_YR  = 3'd1;
    localparam logic [2:0] PH_RR  = 3'd2;
    localparam logic [2:0] PH_RG  = 3'd3;
    localparam logic [2:0] PH_RY  = 3'd4;
    localparam logic [2:0] PH_PED = 3'd5;
    localparam logic [2:0] PH_BAD = 3'd7;

    // Scheduler states.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         r_cur_ph;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_chg_cnt;
    logic [PRESC_W-1:0] r_presc;
    logic               r_step;
    logic               r_fault;
    logic               r_flash;

    logic [2:0]         w_phase;
    logic               w_main_one;
    logic               w_side_one;
    logic               w_tick;
    logic               w_bad;
    logic               w_hold;
    logic [CNT_W-1:0]   w_rem_next;

    // Dwell in ticks for a phase. A zero dwell still counts as one tick, so every
    // phase lasts at least one tick.
    function automatic logic [CNT_W-1:0] dwell_of(input logic [2:0] ph);
        logic [CNT_W-1:0] d;
        case (ph)
            PH_GR:        d = CNT_W'(T_MAIN_GRN);
            PH_YR, PH_RY: d = CNT_W'(T_YEL);
            PH_RR:        d = CNT_W'(T_ALLRED);
            PH_RG:        d = CNT_W'(T_SIDE_GRN);
            PH_PED:       d = CNT_W'(T_PED);
            default:      d = CNT_ONE;
        endcase
        return (d == CNT_ZERO) ? CNT_ONE : d;
    endfunction

    // A legal pattern lights exactly one lamp on each road.
    assign w_main_one = (MG & ~MY & ~MR) | (~MG & MY & ~MR) | (~MG & ~MY & MR);
    assign w_side_one = (SG & ~SY & ~SR) | (~SG & SY & ~SR) | (~SG & ~SY & SR);

    // Decode the lamp pattern into a phase; anything unrecognised is invalid.
    always_comb begin
        w_phase = PH_BAD;
        if (w_main_one && w_side_one) begin
            if (MG && SR) begin
                w_phase = PH_GR;
            end else if (MY && SR) begin
                w_phase = PH_YR;
            end else if (MR && SR && !pedLight) begin
                w_phase = PH_RR;
            end else if (MR && SR && pedLight) begin
                w_phase = PH_PED;
            end else if (MR && SG) begin
                w_phase = PH_RG;
            end else if (MR && SY) begin
                w_phase = PH_RY;
            end else begin
                w_phase = PH_BAD;
            end
        end else begin
            w_phase = PH_BAD;
        end
    end

    assign w_tick = run & (r_presc == PRESC_LAST);
    assign w_bad  = (w_phase == PH_BAD);
    // Main green is held past its minimum while nobody is waiting.
    assign w_hold = (r_cur_ph == PH_GR) & ~sideReq & ~pedOn;

    // Dwell count after this cycle's tick, saturating at zero.
    always_comb begin
        w_rem_next = r_rem;
        if (w_tick && (r_rem != CNT_ZERO)) begin
            w_rem_next = r_rem - CNT_ONE;
        end else begin
            w_rem_next = r_rem;
        end
    end

    // Tick prescaler. Restarts at phase load and at each step, so dwells and the
    // change watchdog are timed from their own start. Frozen while run is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= PRESC_ZERO;
        end else if ((r_state == S_LOAD) || (r_state == S_STEP)) begin
            r_presc <= PRESC_ZERO;
        end else if (run) begin
            r_presc <= (r_presc == PRESC_LAST) ? PRESC_ZERO : (r_presc + PRESC_ONE);
        end else begin
            r_presc <= r_presc;
        end
    end

    // Scheduler FSM: load dwell, count down or hold, pulse step, wait for lamp change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cur_ph  <= PH_GR;
            r_rem     <= CNT_ZERO;
            r_chg_cnt <= CNT_ZERO;
            r_step    <= 1'b0;
            r_fault   <= 1'b0;
            r_flash   <= 1'b0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_rem   <= CNT_ZERO;
                    end else begin
                        r_rem    <= dwell_of(w_phase);
                        r_cur_ph <= w_phase;
                        r_state  <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (w_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_rem   <= CNT_ZERO;
                    end else begin
                        r_rem <= w_rem_next;
                        if (run && (w_rem_next == CNT_ZERO) && !w_hold) begin
                            r_step  <= 1'b1;
                            r_state <= S_STEP;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end
                end
                S_STEP: begin
                    r_chg_cnt <= CNT_ZERO;
                    if (w_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_rem   <= CNT_ZERO;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_bad) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_rem   <= CNT_ZERO;
                    end else if (w_phase != r_cur_ph) begin
                        r_state <= S_LOAD;
                    end else if (w_tick) begin
                        if (r_chg_cnt >= CHG_LAST) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                            r_rem   <= CNT_ZERO;
                        end else begin
                            r_chg_cnt <= r_chg_cnt + CNT_ONE;
                        end
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_FAULT: begin
                    if (w_tick) begin
                        r_flash <= ~r_flash;
                    end else begin
                        r_flash <= r_flash;
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                    r_rem   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign step      = r_step;
    assign phase     = w_phase;
    assign remaining = r_rem;
    assign fault     = r_fault;
    assign flash     = r_flash;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Bench for traffic_phase_timer using small timing parameters.
// Covers a phase-decode table, directed multi-cycle corner sequences, and a
// randomized run against a reference model. The model predicts step and
// remaining by counting ticks elapsed since each phase entry.
module tb_traffic_phase_timer;

    localparam int CPT   = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic             pedOn;
    logic             sideReq;
    logic [6:0]       lamps;        // {MG,MY,MR,SG,SY,SR,pedLight}
    logic             step;
    logic [2:0]       phase;
    logic [CNT_W-1:0] remaining;
    logic             fault;
    logic             flash;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0] lamps;
        logic [2:0] ph;
    } dec_vec_t;

    dec_vec_t tbl [13];

    int first_k, nsteps, trans, frozen_bad;
    logic prev_flash;

    int seq_ph [7] = '{0, 1, 2, 3, 4, 2, 5};
    int seq_i, m_cnt_from, m_elapsed, m_dwell, m_chg_at, exp_rem;
    bit m_stepped, exp_step;

    always #5 clk = ~clk;

    traffic_phase_timer #(
        .CLK_PER_TICK(CPT), .CNT_W(CNT_W), .T_MAIN_GRN(3), .T_YEL(2),
        .T_ALLRED(1), .T_SIDE_GRN(2), .T_PED(2), .T_CHG_TO(2)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .MG(lamps[6]), .MY(lamps[5]), .MR(lamps[4]),
        .SG(lamps[3]), .SY(lamps[2]), .SR(lamps[1]),
        .pedLight(lamps[0]), .pedOn(pedOn), .sideReq(sideReq),
        .step(step), .phase(phase), .remaining(remaining),
        .fault(fault), .flash(flash)
    );

    function automatic logic [6:0] lamps_of(input int ph);
        case (ph)
            0:       return 7'b1000010;
            1:       return 7'b0100010;
            2:       return 7'b0010010;
            3:       return 7'b0011000;
            4:       return 7'b0010100;
            5:       return 7'b0010011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int dwell_ticks(input int ph);
        case (ph)
            0:       return 3;
            1, 4:    return 2;
            2:       return 1;
            3:       return 2;
            5:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Reset with the given lamps, then release. Returns at the first sample after LOAD.
    task automatic start_from_reset(input int ph);
        reset = 1'b1;
        lamps = lamps_of(ph);
        clk1();
        clk1();
        reset = 1'b0;
        clk1();
        clk1();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; run = 1'b1; pedOn = 1'b0; sideReq = 1'b0; lamps = 7'b0000000;

        // ---- phase decode table ----
        tbl[0]  = '{7'b1000010, 3'd0};
        tbl[1]  = '{7'b0100010, 3'd1};
        tbl[2]  = '{7'b0010010, 3'd2};
        tbl[3]  = '{7'b0011000, 3'd3};
        tbl[4]  = '{7'b0010100, 3'd4};
        tbl[5]  = '{7'b0010011, 3'd5};
        tbl[6]  = '{7'b0000000, 3'd7};
        tbl[7]  = '{7'b1001000, 3'd7};
        tbl[8]  = '{7'b1100010, 3'd7};
        tbl[9]  = '{7'b0011010, 3'd7};
        tbl[10] = '{7'b0101000, 3'd7};
        tbl[11] = '{7'b1000011, 3'd0};
        tbl[12] = '{7'b0010000, 3'd7};
        for (int i = 0; i < 13; i++) begin
            lamps = tbl[i].lamps;
            #1;
            check($sformatf("decode%0d", i), 32'(phase), 32'(tbl[i].ph));
        end

        // ---- 1: reset state, GR with side demand, step 12+1 clocks after LOAD ----
        lamps = lamps_of(0); sideReq = 1'b1;
        clk1(); clk1();
        check("rst_step", 32'(step), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_flash", 32'(flash), 32'd0);
        check("rst_rem", 32'(remaining), 32'd0);
        reset = 1'b0;
        clk1(); clk1();
        check("t1_load_rem", 32'(remaining), 32'd3);
        first_k = -1; nsteps = 0;
        for (int k = 1; k <= 14; k++) begin
            clk1();
            if (step) begin
                nsteps++;
                if (first_k < 0) first_k = k;
            end
        end
        check("t1_step_delay", 32'(first_k), 32'd12);
        check("t1_step_count", 32'(nsteps), 32'd1);

        // ---- 3: GR hold without demand, then pedOn releases it ----
        sideReq = 1'b0; pedOn = 1'b0;
        start_from_reset(0);
        check("t3_load_rem", 32'(remaining), 32'd3);
        nsteps = 0;
        for (int k = 0; k < 40; k++) begin
            clk1();
            if (step) nsteps++;
        end
        check("t3_hold_rem", 32'(remaining), 32'd0);
        check("t3_hold_steps", 32'(nsteps), 32'd0);
        pedOn = 1'b1;
        clk1();
        check("t3_ped_step", 32'(step), 32'd1);
        pedOn = 1'b0;

        // ---- 4: lamps never change after the step -> fault after 2 ticks ----
        nsteps = 0;
        for (int k = 1; k <= 9; k++) begin
            clk1();
            if (step) nsteps++;
            if (k == 8) check("t4_fault_early", 32'(fault), 32'd0);
        end
        check("t4_fault", 32'(fault), 32'd1);
        check("t4_flash0", 32'(flash), 32'd0);
        trans = 0; prev_flash = flash;
        for (int k = 0; k < 16; k++) begin
            clk1();
            if (flash !== prev_flash) trans++;
            prev_flash = flash;
            if (step) nsteps++;
        end
        check("t4_flash_toggles", 32'(trans), 32'd4);
        check("t4_no_step", 32'(nsteps), 32'd0);

        // ---- 5: illegal lamps mid-count, then reset recovery ----
        start_from_reset(0);
        clk1(); clk1(); clk1();
        lamps = 7'b1001000;
        #1;
        check("t5_phase_bad", 32'(phase), 32'd7);
        check("t5_fault_pre", 32'(fault), 32'd0);
        clk1();
        check("t5_fault", 32'(fault), 32'd1);
        reset = 1'b1; lamps = lamps_of(0);
        clk1();
        check("t5_rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        clk1(); clk1();
        check("t5_reload_rem", 32'(remaining), 32'd3);

        // ---- 6: run=0 mid-count freezes the dwell ----
        sideReq = 1'b1;
        start_from_reset(0);
        for (int k = 0; k < 5; k++) clk1();
        check("t6_rem_before", 32'(remaining), 32'd2);
        run = 1'b0; frozen_bad = 0;
        for (int k = 0; k < 20; k++) begin
            clk1();
            if (remaining !== 8'd2 || step !== 1'b0) frozen_bad++;
        end
        check("t6_frozen", 32'(frozen_bad), 32'd0);
        run = 1'b1; first_k = -1;
        for (int k = 1; k <= 40; k++) begin
            clk1();
            if (step && first_k < 0) first_k = k;
        end
        check("t6_resume_step", 32'(first_k), 32'd7);

        // ---- randomized run with a model sequencer and reference timing ----
        reset = 1'b1; seq_i = 0; lamps = lamps_of(seq_ph[0]);
        clk1(); clk1();
        reset = 1'b0;
        m_cnt_from = 2; m_elapsed = 0; m_dwell = dwell_ticks(seq_ph[0]);
        m_stepped = 1'b0; m_chg_at = -1; exp_rem = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            if (cyc == m_chg_at) begin
                seq_i = (seq_i + 1) % 7;
                lamps = lamps_of(seq_ph[seq_i]);
                m_cnt_from = cyc + 2;
                m_dwell = dwell_ticks(seq_ph[seq_i]);
                m_elapsed = 0;
                m_stepped = 1'b0;
                m_chg_at = -1;
            end
            run = ($urandom_range(0, 3) != 0);
            sideReq = ($urandom_range(0, 2) == 0);
            pedOn = ($urandom_range(0, 7) == 0);
            exp_step = 1'b0;
            if (cyc == m_cnt_from - 1) begin
                exp_rem = m_dwell;
            end else if (cyc >= m_cnt_from && !m_stepped) begin
                if (run) m_elapsed++;
                exp_rem = (m_elapsed / CPT >= m_dwell) ? 0 : m_dwell - m_elapsed / CPT;
                if (run && m_elapsed >= CPT * m_dwell &&
                    (seq_ph[seq_i] != 0 || sideReq || pedOn)) begin
                    exp_step = 1'b1;
                    m_stepped = 1'b1;
                    m_chg_at = cyc + 2 + int'($urandom_range(0, 2));
                end
            end
            clk1();
            check("rnd_step", 32'(step), 32'(exp_step));
            check("rnd_rem", 32'(remaining), 32'(exp_rem));
            check("rnd_fault", 32'(fault), 32'd0);
            check("rnd_phase", 32'(phase), 32'(seq_ph[seq_i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
